uart_frame_loader: RTL and testbench

UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

---
 rtl/uart_frame_loader_pkg.sv | 31 +++
 rtl/uart_frame_loader.sv | 183 ++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_loader_pkg.sv
// Shared FSM encoding, error codes and frame field offsets for the UART frame loader.
// Frame layout: SYNC TYPE LEN_LO LEN_HI {LEN words, 4 bytes each LSB-first} CSUM.
package uart_frame_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_LEN0,
        ST_LEN1,
        ST_PAYLOAD,
        ST_CSUM
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        OFF_SYNC    = 3'd0,
        OFF_TYPE    = 3'd1,
        OFF_LEN_LO  = 3'd2,
        OFF_LEN_HI  = 3'd3,
        OFF_PAYLOAD = 3'd4
    } field_off_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/uart_frame_loader.sv
// Parses framed UART byte streams into 32-bit memory word writes with checksum.
// Define UART_FRAME_TIMEOUT_EN to abort frames idle for TIMEOUT_CLKS clocks.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
    parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [7:0]        frame_type,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    localparam logic [63:0] LEN_MAX = 64'd1 << ADDR_W;
    localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);

    state_e            state_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       word_q;
    logic [7:0]        type_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic [7:0]        csum_q;
    logic [7:0]        len_lo_q;
    logic [15:0]       wleft_q;
    logic [1:0]        bcnt_q;

    logic [15:0]       len_d;
    logic [31:0]       word_d;
    logic [7:0]        csum_d;

    assign len_d  = {rx_data, len_lo_q};
    assign word_d = {rx_data, word_q[31:8]};
    assign csum_d = csum_q + rx_data;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    logic [TMO_W-1:0] tmo_q;
`else
    logic [31:0] tmo_unused;
    assign tmo_unused = 32'(TIMEOUT_CLKS);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            word_q      <= '0;
            type_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            csum_q      <= '0;
            len_lo_q    <= '0;
            wleft_q     <= '0;
            bcnt_q      <= '0;
`ifdef UART_FRAME_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            // Address advances the cycle after each write strobe.
            if (mem_we_q) mem_addr_q <= mem_addr_q + 1'b1;

            unique case (state_q)
                ST_IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state_q    <= ST_TYPE;
                        busy_q     <= 1'b1;
                        csum_q     <= '0;
                        bcnt_q     <= '0;
                        mem_addr_q <= '0;
                    end
                end
                ST_TYPE: begin
                    if (rx_valid) begin
                        type_q  <= rx_data;
                        csum_q  <= csum_d;
                        state_q <= ST_LEN0;
                    end
                end
                ST_LEN0: begin
                    if (rx_valid) begin
                        len_lo_q <= rx_data;
                        csum_q   <= csum_d;
                        state_q  <= ST_LEN1;
                    end
                end
                ST_LEN1: begin
                    if (rx_valid) begin
                        csum_q <= csum_d;
                        if ({48'd0, len_d} > LEN_MAX) begin
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_LEN;
                        end else if (len_d == 16'd0) begin
                            state_q <= ST_CSUM;
                        end else begin
                            wleft_q <= len_d;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        csum_q <= csum_d;
                        word_q <= word_d;
                        bcnt_q <= bcnt_q + 1'b1;
                        if (bcnt_q == LAST_BYTE) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= word_d;
                            wleft_q     <= wleft_q - 1'b1;
                            if (wleft_q == 16'd1) state_q <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_valid) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (rx_data == csum_q) begin
                            done_q     <= 1'b1;
                            err_code_q <= ERR_NONE;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_CSUM;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

`ifdef UART_FRAME_TIMEOUT_EN
            // A byte on the expiry cycle wins: rx_valid clears the counter first.
            if (state_q == ST_IDLE || rx_valid) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_q      <= '0;
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
`endif
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign frame_type = type_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: frames are encoded by the bench,
// expected writes/events queued at send time and compared against captures.
module tb_uart_frame_loader;

    localparam int unsigned AW   = 10;
    localparam logic [7:0]  SYNC = 8'hAA;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct packed {
        logic       done;
        logic       err;
        logic [1:0] code;
        logic [7:0] ftype;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [7:0]    frame_type;
    logic          busy;
    logic          frame_done;
    logic          frame_err;
    logic [1:0]    err_code;

    int n_checks = 0;
    int n_fail   = 0;

    wr_t exp_wr[$];
    wr_t obs_wr[$];
    ev_t exp_ev[$];
    ev_t obs_ev[$];
    logic [31:0] payload[$];

    uart_frame_loader #(
        .ADDR_W(AW),
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CLKS(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .frame_type(frame_type),
        .busy(busy),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_we) obs_wr.push_back('{addr: mem_addr, data: mem_wdata});
        if (frame_done || frame_err)
            obs_ev.push_back('{done: frame_done, err: frame_err,
                               code: err_code, ftype: frame_type});
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [7:0] ft, input bit bad, input int gap);
        logic [7:0]  s;
        logic [15:0] n;
        logic [7:0]  b;
        n = 16'(payload.size());
        s = ft + n[7:0] + n[15:8];
        send(SYNC, gap);
        send(ft, gap);
        send(n[7:0], gap);
        send(n[15:8], gap);
        for (int i = 0; i < payload.size(); i++) begin
            exp_wr.push_back('{addr: AW'(i), data: payload[i]});
            for (int k = 0; k < 4; k++) begin
                b = payload[i][8*k +: 8];
                s = s + b;
                send(b, gap);
            end
        end
        if (bad) begin
            s = s + 8'd1;
            exp_ev.push_back('{done: 1'b0, err: 1'b1, code: 2'd1, ftype: ft});
        end else begin
            exp_ev.push_back('{done: 1'b1, err: 1'b0, code: 2'd0, ftype: ft});
        end
        send(s, gap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({mem_we, busy, frame_done, frame_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {mem_we, busy, frame_done, frame_err});
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got addr %0d data %h expected 0/0", mem_addr, mem_wdata);
        end
        n_checks++;
        if (frame_type !== 8'h00 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_type_err: got %h/%0d expected 00/0", frame_type, err_code);
        end
        rst = 1'b0;
        tick();
        obs_wr.delete();
        obs_ev.delete();
    endtask

    task automatic test_good_frame();
        wr_t we, wo;
        ev_t ee, eo;
        payload = '{32'h44332211, 32'h88776655};
        send_frame(8'h01, 1'b0, 0);
        repeat (3) tick();
        n_checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++;
            $display("FAIL good_wr_count: got %0d expected %0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            we = exp_wr.pop_front();
            wo = obs_wr.pop_front();
            n_checks++;
            if (wo !== we) begin
                n_fail++;
                $display("FAIL good_wr: got %h@%0d expected %h@%0d", wo.data, wo.addr, we.data, we.addr);
            end
        end
        n_checks++;
        if (obs_ev.size() != 1) begin
            n_fail++;
            $display("FAIL good_ev_count: got %0d expected 1", obs_ev.size());
        end else begin
            ee = exp_ev.pop_front();
            eo = obs_ev.pop_front();
            n_checks++;
            if (eo !== ee) begin
                n_fail++;
                $display("FAIL good_ev: got %h expected %h", eo, ee);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || err_code !== 2'd0 || frame_type !== 8'h01) begin
            n_fail++;
            $display("FAIL good_status: got busy %b err %0d type %h expected 0/0/01",
                     busy, err_code, frame_type);
        end
        exp_wr.delete(); obs_wr.delete(); exp_ev.delete(); obs_ev.delete();
    endtask

    task automatic test_bad_csum();
        wr_t we, wo;
        ev_t ee, eo;
        payload = '{32'h44332211, 32'h88776655};
        send_frame(8'h01, 1'b1, 1);
        repeat (6) tick();
        n_checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++;
            $display("FAIL csum_wr_count: got %0d expected %0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            we = exp_wr.pop_front();
            wo = obs_wr.pop_front();
            n_checks++;
            if (wo !== we) begin
                n_fail++;
                $display("FAIL csum_wr: got %h@%0d expected %h@%0d", wo.data, wo.addr, we.data, we.addr);
            end
        end
        n_checks++;
        if (obs_ev.size() != 1) begin
            n_fail++;
            $display("FAIL csum_ev_count: got %0d expected 1", obs_ev.size());
        end else begin
            ee = exp_ev.pop_front();
            eo = obs_ev.pop_front();
            n_checks++;
            if (eo !== ee) begin
                n_fail++;
                $display("FAIL csum_ev: got %h expected %h", eo, ee);
            end
        end
        n_checks++;
        if (err_code !== 2'd1) begin
            n_fail++;
            $display("FAIL csum_err_hold: got %0d expected 1", err_code);
        end
        exp_wr.delete(); obs_wr.delete(); exp_ev.delete(); obs_ev.delete();
    endtask

    task automatic test_sync_hunt();
        ev_t ee, eo;
        send(8'h00, 0);
        send(8'hFF, 0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hunt_idle: got busy %b expected 0", busy);
        end
        payload.delete();
        send_frame(8'h07, 1'b0, 0);
        repeat (3) tick();
        n_checks++;
        if (obs_wr.size() != 0) begin
            n_fail++;
            $display("FAIL hunt_wr_count: got %0d expected 0", obs_wr.size());
        end
        n_checks++;
        if (obs_ev.size() != 1) begin
            n_fail++;
            $display("FAIL hunt_ev_count: got %0d expected 1", obs_ev.size());
        end else begin
            ee = exp_ev.pop_front();
            eo = obs_ev.pop_front();
            n_checks++;
            if (eo !== ee) begin
                n_fail++;
                $display("FAIL hunt_ev: got %h expected %h", eo, ee);
            end
        end
        n_checks++;
        if (err_code !== 2'd0 || frame_type !== 8'h07) begin
            n_fail++;
            $display("FAIL hunt_status: got err %0d type %h expected 0/07", err_code, frame_type);
        end
        exp_wr.delete(); obs_wr.delete(); exp_ev.delete(); obs_ev.delete();
    endtask

    task automatic test_len_err();
        ev_t ee, eo;
        send(SYNC, 0);
        send(8'h02, 0);
        send(8'h01, 0);
        exp_ev.push_back('{done: 1'b0, err: 1'b1, code: 2'd2, ftype: 8'h02});
        send(8'h04, 0);
        n_checks++;
        if (obs_ev.size() != 1) begin
            n_fail++;
            $display("FAIL len_ev_count: got %0d expected 1", obs_ev.size());
        end else begin
            ee = exp_ev.pop_front();
            eo = obs_ev.pop_front();
            n_checks++;
            if (eo !== ee) begin
                n_fail++;
                $display("FAIL len_ev: got %h expected %h", eo, ee);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || err_code !== 2'd2) begin
            n_fail++;
            $display("FAIL len_status: got busy %b err %0d expected 0/2", busy, err_code);
        end
        exp_ev.delete(); obs_ev.delete(); obs_wr.delete();
    endtask

    task automatic test_back_to_back();
        wr_t we, wo;
        ev_t ee, eo;
        payload = '{32'hAAAAAAAA, 32'h000000AA, 32'hDEADBEEF};
        send_frame(8'h10, 1'b0, 0);
        payload = '{32'h01020304};
        send_frame(8'h11, 1'b0, 2);
        repeat (3) tick();
        n_checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++;
            $display("FAIL b2b_wr_count: got %0d expected %0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            we = exp_wr.pop_front();
            wo = obs_wr.pop_front();
            n_checks++;
            if (wo !== we) begin
                n_fail++;
                $display("FAIL b2b_wr: got %h@%0d expected %h@%0d", wo.data, wo.addr, we.data, we.addr);
            end
        end
        n_checks++;
        if (obs_ev.size() != exp_ev.size()) begin
            n_fail++;
            $display("FAIL b2b_ev_count: got %0d expected %0d", obs_ev.size(), exp_ev.size());
        end
        while (exp_ev.size() > 0 && obs_ev.size() > 0) begin
            ee = exp_ev.pop_front();
            eo = obs_ev.pop_front();
            n_checks++;
            if (eo !== ee) begin
                n_fail++;
                $display("FAIL b2b_ev: got %h expected %h", eo, ee);
            end
        end
        exp_wr.delete(); obs_wr.delete(); exp_ev.delete(); obs_ev.delete();
    endtask

    task automatic test_reset_abort();
        wr_t we, wo;
        send(SYNC, 0);
        send(8'h05, 0);
        send(8'h00, 0);
        send(8'h04, 0);
        n_checks++;
        if (busy !== 1'b1 || obs_ev.size() != 0) begin
            n_fail++;
            $display("FAIL len_max_accept: got busy %b events %0d expected 1/0", busy, obs_ev.size());
        end
        send(8'h12, 0);
        send(8'h34, 0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (obs_wr.size() != 0 || obs_ev.size() != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: got writes %0d events %0d expected 0/0", obs_wr.size(), obs_ev.size());
        end
        n_checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_status: got busy %b err %b expected 0/0", busy, frame_err);
        end
        payload = '{32'hCAFEF00D};
        send_frame(8'h06, 1'b0, 0);
        repeat (3) tick();
        n_checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++;
            $display("FAIL reload_wr_count: got %0d expected %0d", obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            we = exp_wr.pop_front();
            wo = obs_wr.pop_front();
            n_checks++;
            if (wo !== we) begin
                n_fail++;
                $display("FAIL reload_wr: got %h@%0d expected %h@%0d", wo.data, wo.addr, we.data, we.addr);
            end
        end
        n_checks++;
        if (obs_ev.size() != 1 || frame_type !== 8'h06) begin
            n_fail++;
            $display("FAIL reload_ev: got events %0d type %h expected 1/06", obs_ev.size(), frame_type);
        end
        exp_wr.delete(); obs_wr.delete(); exp_ev.delete(); obs_ev.delete();
    endtask

    task automatic test_timeout();
        ev_t ee, eo;
        send(SYNC, 0);
        send(8'h01, 0);
        repeat (99) tick();
        n_checks++;
        if (busy !== 1'b1 || obs_ev.size() != 0) begin
            n_fail++;
            $display("FAIL tmo_early: got busy %b events %0d expected 1/0", busy, obs_ev.size());
        end
`ifdef UART_FRAME_TIMEOUT_EN
        exp_ev.push_back('{done: 1'b0, err: 1'b1, code: 2'd3, ftype: 8'h01});
        tick();
        n_checks++;
        if (obs_ev.size() != 1) begin
            n_fail++;
            $display("FAIL tmo_ev_count: got %0d expected 1", obs_ev.size());
        end else begin
            ee = exp_ev.pop_front();
            eo = obs_ev.pop_front();
            n_checks++;
            if (eo !== ee) begin
                n_fail++;
                $display("FAIL tmo_ev: got %h expected %h", eo, ee);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || err_code !== 2'd3) begin
            n_fail++;
            $display("FAIL tmo_status: got busy %b err %0d expected 0/3", busy, err_code);
        end
`else
        repeat (60) tick();
        exp_ev.push_back('{done: 1'b1, err: 1'b0, code: 2'd0, ftype: 8'h01});
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        n_checks++;
        if (obs_ev.size() != 1) begin
            n_fail++;
            $display("FAIL notmo_ev_count: got %0d expected 1", obs_ev.size());
        end else begin
            ee = exp_ev.pop_front();
            eo = obs_ev.pop_front();
            n_checks++;
            if (eo !== ee) begin
                n_fail++;
                $display("FAIL notmo_ev: got %h expected %h", eo, ee);
            end
        end
`endif
        exp_ev.delete(); obs_ev.delete(); obs_wr.delete();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_sync_hunt();
        test_len_err();
        test_back_to_back();
        test_reset_abort();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
